ir_packet_sm: RTL and testbench

//  Per-car IR packet generator, one instance per car colour inside the IR transmitter wrapper.
//  On each SEND_PACKET trigger (10 Hz counter) it serialises a captured 4-bit direction command

---
 rtl/ir_packet_if.sv | 28 ++
 rtl/ir_packet_sm.sv | 137 +++++++++++++
 tb/tb_ir_packet_sm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_packet_if.sv
// Control and status bundle between the IR transmitter wrapper and one
// per-car packet generator.
interface ir_packet_if;
   logic       enable;
   logic       send_packet;
   logic [3:0] command;
   logic       ir_led;
   logic       busy;
   logic       packet_done;

   modport master (
      output enable,
      output send_packet,
      output command,
      input  ir_led,
      input  busy,
      input  packet_done
   );

   modport slave (
      input  enable,
      input  send_packet,
      input  command,
      output ir_led,
      output busy,
      output packet_done
   );
endinterface

// File: rtl/ir_packet_sm.sv
// Per-car IR packet generator: serialises a captured direction command
// into Start/CarSelect/R/L/B/F carrier bursts, each followed by a gap.
module ir_packet_sm #(
   parameter int START_BURST    = 191,
   parameter int CARSEL_BURST   = 47,
   parameter int ASSERT_BURST   = 47,
   parameter int DEASSERT_BURST = 22,
   parameter int GAP            = 25,
   parameter int CARRIER_PERIOD = 2778
) (
   input  logic     clk,
   input  logic     reset,
   ir_packet_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_GAP
   } state_t;

   localparam logic [11:0] CAR_LAST = 12'(CARRIER_PERIOD - 1);
   localparam logic [11:0] CAR_HALF = 12'(CARRIER_PERIOD / 2);
   localparam logic [7:0]  START_LAST  = 8'(START_BURST - 1);
   localparam logic [7:0]  CARSEL_LAST = 8'(CARSEL_BURST - 1);
   localparam logic [7:0]  ASSERT_LAST = 8'(ASSERT_BURST - 1);
   localparam logic [7:0]  DEASSERT_LAST = 8'(DEASSERT_BURST - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
   localparam logic [2:0]  LAST_FIELD = 3'd5;

   state_t      state;
   logic [2:0]  field;
   logic [11:0] car;
   logic [7:0]  bcnt;
   logic [3:0]  cmd_q;
   logic        done_q;

   logic        tick;
   logic        cmd_bit;
   logic [7:0]  burst_last;
   logic        burst_end;
   logic        gap_end;

   // Command fields 2..5 map onto cmd_q[0..3]
   always_comb begin
      cmd_bit = 1'b0;
      unique case (field)
         3'd2:    cmd_bit = cmd_q[0];
         3'd3:    cmd_bit = cmd_q[1];
         3'd4:    cmd_bit = cmd_q[2];
         3'd5:    cmd_bit = cmd_q[3];
         default: cmd_bit = 1'b0;
      endcase
   end

   always_comb begin
      burst_last = DEASSERT_LAST;
      unique case (1'b1)
         (field == 3'd0): burst_last = START_LAST;
         (field == 3'd1): burst_last = CARSEL_LAST;
         cmd_bit:         burst_last = ASSERT_LAST;
         default:         burst_last = DEASSERT_LAST;
      endcase
   end

   assign tick      = (car == CAR_LAST);
   assign burst_end = tick && (bcnt == burst_last);
   assign gap_end   = tick && (bcnt == GAP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         field  <= '0;
         car    <= '0;
         bcnt   <= '0;
         cmd_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state != S_IDLE && !bus.enable) begin
            // Car deselected: drop the packet silently
            state <= S_IDLE;
            field <= '0;
            car   <= '0;
            bcnt  <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (bus.enable && bus.send_packet) begin
                     state <= S_BURST;
                     field <= '0;
                     car   <= '0;
                     bcnt  <= '0;
                     cmd_q <= bus.command;
                  end
               end
               S_BURST: begin
                  car <= tick ? '0 : car + 12'd1;
                  if (burst_end) begin
                     state <= S_GAP;
                     bcnt  <= '0;
                  end else if (tick) begin
                     bcnt <= bcnt + 8'd1;
                  end
               end
               S_GAP: begin
                  car <= tick ? '0 : car + 12'd1;
                  if (gap_end) begin
                     bcnt <= '0;
                     if (field == LAST_FIELD) begin
                        state  <= S_IDLE;
                        field  <= '0;
                        done_q <= 1'b1;
                     end else begin
                        state <= S_BURST;
                        field <= field + 3'd1;
                     end
                  end else if (tick) begin
                     bcnt <= bcnt + 8'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  field <= '0;
                  car   <= '0;
                  bcnt  <= '0;
               end
            endcase
         end
      end
   end

   assign bus.ir_led      = (state == S_BURST) && (car < CAR_HALF);
   assign bus.busy        = (state != S_IDLE);
   assign bus.packet_done = done_q;

endmodule

// File: tb/tb_ir_packet_sm.sv
// Bench for ir_packet_sm: expected per-cycle waveforms are expanded from
// the packet protocol into a queue and compared cycle by cycle.
module tb_ir_packet_sm;

   localparam int CP = 4;
   localparam int SB = 3;
   localparam int CB = 2;
   localparam int AB = 2;
   localparam int DB = 1;
   localparam int GP = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;

   ir_packet_if bus ();

   ir_packet_sm #(
      .START_BURST    (SB),
      .CARSEL_BURST   (CB),
      .ASSERT_BURST   (AB),
      .DEASSERT_BURST (DB),
      .GAP            (GAP_P()),
      .CARRIER_PERIOD (CP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic int GAP_P();
      return GP;
   endfunction

   always #5 clk = ~clk;

   typedef struct {
      logic led;
      logic busy;
      logic done;
   } exp_t;

   typedef struct {
      logic [3:0] cmd;
      logic [3:0] new_cmd;
      int         chg_at;
      int         exp_busy;
      int         exp_led;
   } vec_t;

   exp_t q[$];
   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_out(input string tag, input exp_t e);
      chk({tag, " ir_led"}, 32'(bus.ir_led), 32'(e.led));
      chk({tag, " busy"}, 32'(bus.busy), 32'(e.busy));
      chk({tag, " done"}, 32'(bus.packet_done), 32'(e.done));
   endtask

   function automatic exp_t mk(input logic l, input logic b, input logic d);
      exp_t e;
      e.led  = l;
      e.busy = b;
      e.done = d;
      return e;
   endfunction

   // Expand one packet into its cycle-by-cycle output, ending with the
   // PACKET_DONE idle cycle.
   task automatic push_packet(input logic [3:0] c);
      int len [6];
      len[0] = SB;
      len[1] = CB;
      for (int b = 0; b < 4; b++) len[b+2] = c[b] ? AB : DB;
      for (int f = 0; f < 6; f++) begin
         for (int p = 0; p < len[f]; p++)
            for (int k = 0; k < CP; k++)
               q.push_back(mk(k < CP / 2, 1'b1, 1'b0));
         for (int p = 0; p < GP; p++)
            for (int k = 0; k < CP; k++)
               q.push_back(mk(1'b0, 1'b1, 1'b0));
      end
      q.push_back(mk(1'b0, 1'b0, 1'b1));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   cyc;
      int   n_busy;
      int   n_led;
      exp_t e;
      cyc    = 0;
      n_busy = 0;
      n_led  = 0;
      bus.command = v.cmd;
      push_packet(v.cmd);
      bus.send_packet = 1'b1;
      while (q.size() > 0) begin
         step();
         cyc++;
         if (cyc == 1) bus.send_packet = 1'b0;
         if (cyc == v.chg_at) bus.command = v.new_cmd;
         e = q.pop_front();
         check_out(tag, e);
         n_busy += int'(bus.busy);
         n_led  += int'(bus.ir_led);
      end
      chk({tag, " busy cycles"}, 32'(n_busy), 32'(v.exp_busy));
      chk({tag, " led cycles"}, 32'(n_led), 32'(v.exp_led));
      step();
      check_out({tag, " after"}, mk(1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      exp_t e;
      int   cyc;
      int   n_done;

      vecs[0] = '{cmd: 4'b1001, new_cmd: 4'b1001, chg_at: 0,
                  exp_busy: 92, exp_led: 22};
      vecs[1] = '{cmd: 4'b1001, new_cmd: 4'b0110, chg_at: 10,
                  exp_busy: 92, exp_led: 22};
      vecs[2] = '{cmd: 4'b0000, new_cmd: 4'b0000, chg_at: 0,
                  exp_busy: 84, exp_led: 18};
      vecs[3] = '{cmd: 4'b1111, new_cmd: 4'b1111, chg_at: 0,
                  exp_busy: 100, exp_led: 26};
      vecs[4] = '{cmd: 4'b0110, new_cmd: 4'b0110, chg_at: 0,
                  exp_busy: 92, exp_led: 22};
      vecs[5] = '{cmd: 4'b0101, new_cmd: 4'b0000, chg_at: 30,
                  exp_busy: 92, exp_led: 22};

      bus.enable      = 1'b0;
      bus.send_packet = 1'b0;
      bus.command     = 4'b0000;

      // Reset held: outputs stay quiet whatever the inputs do
      for (int i = 0; i < 20; i++) begin
         bus.enable      = 1'($urandom_range(0, 1));
         bus.send_packet = 1'($urandom_range(0, 1));
         bus.command     = 4'($urandom_range(0, 15));
         step();
         check_out("reset hold", mk(1'b0, 1'b0, 1'b0));
      end
      bus.enable      = 1'b0;
      bus.send_packet = 1'b0;
      bus.command     = 4'b0000;
      reset = 1'b1;
      step();
      bus.enable = 1'b1;
      step();
      check_out("idle", mk(1'b0, 1'b0, 1'b0));

      for (int i = 0; i < 6; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Held SEND_PACKET: back-to-back packets, one idle cycle between
      bus.command = 4'b0000;
      push_packet(4'b0000);
      push_packet(4'b0000);
      for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
      bus.send_packet = 1'b1;
      cyc    = 0;
      n_done = 0;
      while (q.size() > 0) begin
         step();
         cyc++;
         if (cyc == 100) bus.send_packet = 1'b0;
         e = q.pop_front();
         check_out("held send", e);
         n_done += int'(bus.packet_done);
      end
      chk("held send done pulses", 32'(n_done), 32'd2);

      // ENABLE dropped mid-packet
      bus.command = 4'b1001;
      push_packet(4'b1001);
      bus.send_packet = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 1) bus.send_packet = 1'b0;
         e = q.pop_front();
         check_out("pre abort", e);
      end
      q.delete();
      bus.enable = 1'b0;
      n_done = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         check_out("aborted", mk(1'b0, 1'b0, 1'b0));
         n_done += int'(bus.packet_done);
      end
      chk("abort done pulses", 32'(n_done), 32'd0);
      bus.send_packet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_out("send disabled", mk(1'b0, 1'b0, 1'b0));
      end
      bus.send_packet = 1'b0;
      bus.enable = 1'b1;
      step();

      // Asynchronous reset inside the Start burst while the LED is lit
      push_packet(4'b1001);
      bus.send_packet = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) bus.send_packet = 1'b0;
         e = q.pop_front();
         check_out("pre reset", e);
      end
      chk("pre reset led lit", 32'(bus.ir_led), 32'd1);
      q.delete();
      #1 reset = 1'b0;
      #1 check_out("async reset", mk(1'b0, 1'b0, 1'b0));
      step();
      step();
      reset = 1'b1;
      step();
      run_vec(vecs[0], "post reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
